// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - accumulator ALU feeding a DEPTH-entry result FIFO over valid/ready handshakes
package alu_pipe_pkg;
    typedef enum logic [2:0] {HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP} opcode_t;
endpackage

module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 2,
    parameter int SATURATE = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           accum,
    input  logic [WIDTH-1:0]           data,
    input  opcode_t                    opcode,
    output logic                       acc_zero,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out,
    output logic                       carry,
    output logic                       ovf,
    output logic                       neg,
    output logic                       res_zero,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = WIDTH + 3;

    logic [EW-1:0]    r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_result;
    logic             w_carry;
    logic             w_ovf;
    logic [AW-1:0]    w_head_idx;
    logic [EW-1:0]    w_head;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    // Push is gated on pre-edge fullness only, so a full FIFO never passes through on a pop edge.
    assign w_push  = in_valid && !w_full;
    assign w_pop   = out_ready && !w_empty;

    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign count     = r_count;
    assign acc_zero  = ~|accum;

    assign w_sum = {1'b0, accum} + {1'b0, data};

    always_comb begin
        w_result = accum;
        w_carry  = 1'b0;
        w_ovf    = 1'b0;
        case (opcode)
            ADD: begin
                w_carry  = w_sum[WIDTH];
                w_ovf    = (accum[WIDTH-1] == data[WIDTH-1]) && (w_sum[WIDTH-1] != accum[WIDTH-1]);
                w_result = ((SATURATE != 0) && w_sum[WIDTH]) ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
            end
            AND:     w_result = accum & data;
            XOR:     w_result = accum ^ data;
            LDA:     w_result = data;
            default: w_result = accum;
        endcase
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {(w_result == '0), w_carry, w_ovf, w_result};
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // When empty, present the most recently popped slot rather than a stale older one.
    assign w_head_idx = w_empty ? (r_rd_ptr - AW'(1)) : r_rd_ptr;
    assign w_head     = r_mem[w_head_idx];

    assign out      = w_head[WIDTH-1:0];
    assign ovf      = w_head[WIDTH];
    assign carry    = w_head[WIDTH+1];
    assign res_zero = w_head[WIDTH+2];
    assign neg      = w_head[WIDTH-1];
endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - randomized and directed check of alu_pipe against a queue-based reference
module tb_alu_pipe;
    import alu_pipe_pkg::*;

    localparam int DEPTH = 2;

    typedef struct {
        bit [7:0] res;
        bit [7:0] res_s;
        bit       c;
        bit       v;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] accum = '0;
    logic [7:0] data = '0;
    opcode_t    opcode = HLT;
    logic       out_ready = 1'b0;

    logic       in_ready, acc_zero, out_valid, carry, ovf, neg, res_zero;
    logic [7:0] out;
    logic [1:0] count;
    logic       s_in_ready, s_acc_zero, s_out_valid, s_carry, s_ovf, s_neg, s_res_zero;
    logic [7:0] s_out;
    logic [1:0] s_count;

    int   n_vec = 0;
    int   n_err = 0;
    ent_t q[$];

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(8), .DEPTH(DEPTH), .SATURATE(0)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .accum(accum), .data(data), .opcode(opcode), .acc_zero(acc_zero),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .carry(carry),
        .ovf(ovf), .neg(neg), .res_zero(res_zero), .count(count)
    );

    alu_pipe #(.WIDTH(8), .DEPTH(DEPTH), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .accum(accum), .data(data), .opcode(opcode), .acc_zero(s_acc_zero),
        .out_valid(s_out_valid), .out_ready(out_ready), .out(s_out), .carry(s_carry),
        .ovf(s_ovf), .neg(s_neg), .res_zero(s_res_zero), .count(s_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic ent_t model(input bit [7:0] a, input bit [7:0] d, input bit [2:0] op);
        ent_t e;
        int   u, s, sa, sd;
        sa = (a >= 8'd128) ? int'(a) - 256 : int'(a);
        sd = (d >= 8'd128) ? int'(d) - 256 : int'(d);
        u  = int'(a) + int'(d);
        s  = sa + sd;
        e.c = 1'b0;
        e.v = 1'b0;
        case (op)
            3'd2: begin
                e.res = u[7:0];
                e.c   = (u > 255);
                e.v   = (s > 127) || (s < -128);
            end
            3'd3:    e.res = a & d;
            3'd4:    e.res = a ^ d;
            3'd5:    e.res = d;
            default: e.res = a;
        endcase
        e.res_s = (op == 3'd2 && e.c) ? 8'hFF : e.res;
        return e;
    endfunction

    task automatic check_state();
        chk("count", 32'(count), 32'(q.size()));
        chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("sat_count", 32'(s_count), 32'(q.size()));
        chk("sat_in_ready", 32'(s_in_ready), 32'(q.size() < DEPTH));
        chk("sat_out_valid", 32'(s_out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("out", 32'(out), 32'(q[0].res));
            chk("carry", 32'(carry), 32'(q[0].c));
            chk("ovf", 32'(ovf), 32'(q[0].v));
            chk("neg", 32'(neg), 32'(q[0].res >= 8'd128));
            chk("res_zero", 32'(res_zero), 32'(q[0].res == 8'd0));
            chk("sat_out", 32'(s_out), 32'(q[0].res_s));
            chk("sat_carry", 32'(s_carry), 32'(q[0].c));
            chk("sat_ovf", 32'(s_ovf), 32'(q[0].v));
            chk("sat_neg", 32'(s_neg), 32'(q[0].res_s >= 8'd128));
            chk("sat_res_zero", 32'(s_res_zero), 32'(q[0].res_s == 8'd0));
        end
    endtask

    task automatic cyc(input bit iv, input bit [7:0] a, input bit [7:0] d,
                       input bit [2:0] op, input bit ordy, output bit accepted);
        bit push, pop;
        @(posedge clk);
        #1;
        in_valid  = iv;
        accum     = a;
        data      = d;
        opcode    = opcode_t'(op);
        out_ready = ordy;
        #1;
        check_state();
        chk("acc_zero", 32'(acc_zero), 32'(a == 8'd0));
        chk("sat_acc_zero", 32'(s_acc_zero), 32'(a == 8'd0));
        push = iv && (q.size() < DEPTH);
        pop  = ordy && (q.size() > 0);
        @(negedge clk);
        if (pop) void'(q.pop_front());
        if (push) q.push_back(model(a, d, op));
        accepted = push;
    endtask

    initial begin
        bit       acc;
        bit       pend;
        bit [7:0] ra, rd;
        bit [2:0] rop;

        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_carry", 32'(carry), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_neg", 32'(neg), 32'd0);
        chk("rst_res_zero", 32'(res_zero), 32'd0);
        rst = 1'b0;

        // Directed ADD edge cases, saturating instance checked alongside
        cyc(1'b1, 8'h7F, 8'h01, 3'd2, 1'b1, acc);
        cyc(1'b1, 8'hFF, 8'h01, 3'd2, 1'b1, acc);
        cyc(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, acc);
        cyc(1'b0, 8'h01, 8'h00, 3'd0, 1'b1, acc);

        for (int op = 0; op < 8; op++) begin
            cyc(1'b1, 8'hC3, 8'h5A, 3'(op), 1'b1, acc);
        end
        cyc(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, acc);

        // Fill with consumer stalled; third transaction held until a slot frees
        cyc(1'b1, 8'h10, 8'h01, 3'd2, 1'b0, acc);
        cyc(1'b1, 8'h20, 8'h02, 3'd2, 1'b0, acc);
        cyc(1'b1, 8'h30, 8'h03, 3'd2, 1'b0, acc);
        chk("held_while_full", 32'(acc), 32'd0);
        cyc(1'b1, 8'h30, 8'h03, 3'd2, 1'b1, acc);
        chk("held_on_pop_edge", 32'(acc), 32'd0);
        cyc(1'b1, 8'h30, 8'h03, 3'd2, 1'b1, acc);
        chk("accepted_after_pop", 32'(acc), 32'd1);
        repeat (3) cyc(1'b0, 8'h01, 8'h00, 3'd0, 1'b1, acc);

        // Continuous streaming through pointer wrap
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 1'b1, acc);
        end
        cyc(1'b0, 8'h05, 8'h00, 3'd0, 1'b1, acc);

        // Reset mid-stream with two entries queued
        cyc(1'b1, 8'h11, 8'h22, 3'd2, 1'b0, acc);
        cyc(1'b1, 8'h33, 8'h44, 3'd3, 1'b0, acc);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        accum    = 8'h00;
        rst      = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_acc_zero", 32'(acc_zero), 32'd1);
        accum = 8'h01;
        #1;
        chk("mid_rst_acc_nonzero", 32'(acc_zero), 32'd0);
        q.delete();
        rst = 1'b0;

        // Random traffic with producer holding operands until accepted
        pend = 1'b0;
        ra   = '0;
        rd   = '0;
        rop  = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pend && $urandom_range(0, 3) != 0) begin
                pend = 1'b1;
                ra   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
                rd   = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
                rop  = 3'($urandom_range(0, 7));
            end
            cyc(pend, ra, rd, rop, ($urandom_range(0, 2) != 0), acc);
            if (acc) pend = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
